// File: rtl/hram_led_status_ctrl.sv
// Drives the LED PIO over Avalon-MM from the test status: steady, chase or blink.
// A single write is issued whenever the derived pattern differs from what the PIO last accepted.
module hram_led_status_ctrl #(
  parameter int unsigned TICK_CYCLES = 12_500_000,
  parameter int unsigned LED_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 test_start,
  input  logic                 test_done,
  input  logic                 test_pass,
  input  logic [LED_WIDTH-1:0] err_code,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic                 avm_waitrequest,
  output logic [LED_WIDTH-1:0] led_shadow,
  output logic [1:0]           status
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [LED_WIDTH-1:0] LED_ONE = LED_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } status_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wstate_t;

  status_t              status_q;
  status_t              status_nxt;
  wstate_t              wstate_q;
  logic [CW-1:0]        tick_cnt;
  logic [LED_WIDTH-1:0] chase_q;
  logic [LED_WIDTH-1:0] err_q;
  logic [LED_WIDTH-1:0] target_q;
  logic                 blink_on_q;
  logic                 status_chg;
  logic                 counting;
  logic                 tick;
  logic [LED_WIDTH-1:0] err_sel;
  logic [LED_WIDTH-1:0] chase_rot;

  // test_done takes priority over test_start while running
  always_comb begin
    status_nxt = status_q;
    case (status_q)
      ST_IDLE: if (test_start) status_nxt = ST_RUN;
      ST_RUN:  if (test_done)  status_nxt = test_pass ? ST_PASS : ST_FAIL;
      default: if (test_start) status_nxt = ST_RUN;
    endcase
  end

  assign status_chg  = (status_nxt != status_q);
  assign counting    = (status_q == ST_RUN) || (status_q == ST_FAIL);
  assign tick        = counting && !status_chg && (tick_cnt == TICK_LAST);
  assign err_sel     = (err_code == '0) ? '1 : err_code;
  assign chase_rot   = {chase_q[LED_WIDTH-2:0], chase_q[LED_WIDTH-1]};
  assign status      = status_q;
  assign avm_address = 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q   <= ST_IDLE;
      tick_cnt   <= '0;
      chase_q    <= LED_ONE;
      err_q      <= '0;
      blink_on_q <= 1'b1;
      target_q   <= LED_ONE;
    end else begin
      status_q <= status_nxt;
      if (status_chg || !counting || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      // entry values are shown immediately; animation advances only on ticks
      if (status_chg) begin
        case (status_nxt)
          ST_RUN: begin
            chase_q  <= LED_ONE;
            target_q <= LED_ONE;
          end
          ST_PASS: target_q <= '1;
          ST_FAIL: begin
            err_q      <= err_sel;
            blink_on_q <= 1'b1;
            target_q   <= err_sel;
          end
          default: target_q <= LED_ONE;
        endcase
      end else if (tick) begin
        if (status_q == ST_RUN) begin
          chase_q  <= chase_rot;
          target_q <= chase_rot;
        end else begin
          blink_on_q <= !blink_on_q;
          target_q   <= blink_on_q ? '0 : err_q;
        end
      end
    end
  end

  // the in-flight write is frozen; newer targets are picked up after acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate_q       <= W_IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      led_shadow     <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (target_q != led_shadow) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= {{(32-LED_WIDTH){1'b0}}, target_q};
            wstate_q       <= W_REQ;
          end
        end
        default: begin
          if (!avm_waitrequest) begin
            led_shadow     <= avm_writedata[LED_WIDTH-1:0];
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            wstate_q       <= W_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hram_led_status_ctrl.sv
// Bench for hram_led_status_ctrl: directed phases plus random pulses against a cycle-level reference.
module tb_hram_led_status_ctrl;
  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        test_start = 1'b0;
  logic        test_done = 1'b0;
  logic        test_pass = 1'b0;
  logic [3:0]  err_code = 4'h0;
  logic        avm_waitrequest = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [3:0]  led_shadow;
  logic [1:0]  status;

  hram_led_status_ctrl #(.TICK_CYCLES(TICK), .LED_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .test_start(test_start), .test_done(test_done), .test_pass(test_pass),
    .err_code(err_code),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .led_shadow(led_shadow), .status(status)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dut_writes = 0;

  // reference: status, edges since entering it, and the pending-write view of the PIO
  int         m_status;
  int         m_k;
  logic [3:0] m_err;
  logic [3:0] m_target;
  logic [3:0] m_shadow;
  logic       m_cs;
  logic [3:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pattern(input int st, input int k, input logic [3:0] e);
    case (st)
      1:       return 4'(1 << ((k / TICK) % 4));
      2:       return 4'hF;
      3:       return (((k / TICK) % 2) == 0) ? e : 4'h0;
      default: return 4'h1;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 0; m_k = 0; m_err = 4'h0; m_target = 4'h1;
    m_shadow = 4'h0; m_cs = 1'b0; m_data = 4'h0;
  endtask

  task automatic model_step();
    int nxt;
    if (m_cs) begin
      if (!avm_waitrequest) begin
        m_shadow = m_data;
        m_cs = 1'b0;
      end
    end else if (m_target != m_shadow) begin
      m_cs = 1'b1;
      m_data = m_target;
    end
    nxt = m_status;
    if (m_status == 1) begin
      if (test_done) nxt = test_pass ? 2 : 3;
    end else if (test_start) begin
      nxt = 1;
    end
    if (nxt != m_status) begin
      m_k = 0;
      if (nxt == 3) m_err = (err_code == 4'h0) ? 4'hF : err_code;
      m_status = nxt;
    end else begin
      m_k++;
    end
    m_target = pattern(m_status, m_k, m_err);
  endtask

  task automatic check_all();
    chk("status", 32'(status), 32'(m_status));
    chk("chipselect", 32'(avm_chipselect), 32'(m_cs));
    chk("write_n", 32'(avm_write_n), 32'(!m_cs));
    chk("address", 32'(avm_address), 32'd0);
    chk("led_shadow", 32'(led_shadow), 32'(m_shadow));
    if (m_cs) chk("writedata", avm_writedata, 32'(m_data));
  endtask

  task automatic cycle();
    if (avm_chipselect && !avm_waitrequest) dut_writes++;
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_start();
    test_start = 1'b1; cycle(); test_start = 1'b0;
  endtask

  task automatic pulse_done(input logic pass, input logic [3:0] code);
    test_done = 1'b1; test_pass = pass; err_code = code;
    cycle();
    test_done = 1'b0; test_pass = 1'b0; err_code = 4'h0;
  endtask

  task automatic wait_cs(input string tag);
    int i = 0;
    while (!avm_chipselect && i < 50) begin
      cycle();
      i++;
    end
    chk(tag, 32'(avm_chipselect), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_all();
    run(3);
    reset_n = 1'b1;
    dut_writes = 0;
    run(20);
    chk("idle_write_count", 32'(dut_writes), 32'd1);
    chk("idle_shadow", 32'(led_shadow), 32'h1);

    pulse_start();
    run(24);

    pulse_done(1'b1, 4'h0);
    run(5);
    chk("pass_shadow", 32'(led_shadow), 32'hF);
    dut_writes = 0;
    run(100);
    chk("pass_quiet", 32'(dut_writes), 32'd0);

    pulse_start();
    run(3);
    pulse_done(1'b0, 4'h5);
    run(20);

    pulse_start();
    run(3);
    pulse_done(1'b0, 4'h0);
    run(20);

    pulse_start();
    run(2);
    wait_cs("stall_cs");
    held = avm_writedata;
    avm_waitrequest = 1'b1;
    repeat (10) begin
      cycle();
      chk("stall_data", avm_writedata, held);
      chk("stall_addr", 32'(avm_address), 32'd0);
    end
    avm_waitrequest = 1'b0;
    run(12);

    test_start = 1'b1;
    pulse_done(1'b1, 4'h0);
    test_start = 1'b0;
    chk("both_pulses_pass", 32'(status), 32'd2);
    pulse_start();
    run(2);
    test_start = 1'b1;
    pulse_done(1'b0, 4'h9);
    test_start = 1'b0;
    chk("both_pulses_fail", 32'(status), 32'd3);
    run(10);

    repeat (2000) begin
      test_start = ($urandom_range(0, 15) == 0);
      test_done = ($urandom_range(0, 15) == 0);
      test_pass = 1'($urandom);
      err_code = 4'($urandom);
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      cycle();
    end
    test_start = 1'b0; test_done = 1'b0; test_pass = 1'b0;
    err_code = 4'h0; avm_waitrequest = 1'b0;
    run(5);

    pulse_start();
    wait_cs("rst_cs");
    avm_waitrequest = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cs_drop", 32'(avm_chipselect), 32'd0);
    chk("rst_shadow", 32'(led_shadow), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    model_reset();
    avm_waitrequest = 1'b0;
    cycle();
    reset_n = 1'b1;
    dut_writes = 0;
    run(10);
    chk("rst_rewrite_count", 32'(dut_writes), 32'd1);
    chk("rst_rewrite_shadow", 32'(led_shadow), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
